// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for decode_stage.
// The master side drives instructions and consumes decodes; the slave side is the stage itself.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_alu_sel;
    logic        out_alu_ext;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_sel, out_alu_ext, out_imm,
               out_use_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_alu_sel, out_alu_ext, out_imm,
               out_use_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry pipeline register with decode of the held instruction.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables illegal-instruction detection.
module decode_stage #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        w_inReady;
    logic [2:0]  w_f3;
    logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
    logic [2:0]  w_sel;
    logic        w_ext;
    logic [31:0] w_imm;
    logic        w_useImm;
    logic        w_writes;
    logic        w_illegal;

    assign w_inReady = !r_valid || bus.out_ready;
    assign w_f3      = r_inst[14:12];
    assign w_immI    = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_immS    = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_immB    = {{20{r_inst[31]}}, r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_immU    = {r_inst[31:12], 12'b0};
    assign w_immJ    = {{12{r_inst[31]}}, r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

    // The raw instruction is held and decoded on the output side, so reset to NOP_INST yields the NOP decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= 32'h0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (bus.in_valid && w_inReady) begin
            r_valid <= 1'b1;
            r_inst  <= bus.in_inst;
            r_pc    <= bus.in_pc;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_comb begin
        w_sel    = 3'd0;
        w_ext    = 1'b0;
        w_imm    = 32'h0;
        w_useImm = 1'b0;
        w_writes = 1'b0;
        case (r_inst[6:0])
            OPC_OP: begin
                w_sel    = w_f3;
                w_ext    = r_inst[30];
                w_writes = 1'b1;
            end
            OPC_OPIMM: begin
                w_sel    = w_f3;
                w_useImm = 1'b1;
                w_writes = 1'b1;
                w_ext    = (w_f3 == 3'd5) ? r_inst[30] : 1'b0;
                w_imm    = (w_f3 == 3'd1 || w_f3 == 3'd5) ? {27'b0, r_inst[24:20]} : w_immI;
            end
            OPC_LOAD, OPC_JALR: begin
                w_imm    = w_immI;
                w_useImm = 1'b1;
                w_writes = 1'b1;
            end
            OPC_STORE: begin
                w_imm    = w_immS;
                w_useImm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm    = w_immU;
                w_useImm = 1'b1;
                w_writes = 1'b1;
            end
            OPC_JAL: begin
                w_imm    = w_immJ;
                w_useImm = 1'b1;
                w_writes = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm = w_immB;
                case (w_f3)
                    3'd0, 3'd1: w_ext = 1'b1;
                    3'd4, 3'd5: w_sel = 3'd2;
                    3'd6, 3'd7: w_sel = 3'd3;
                    default:    w_sel = 3'd0;
                endcase
            end
            default: w_writes = 1'b0;
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Every known opcode ends in 2'b11, so the unknown-opcode case also covers compressed encodings.
    always_comb begin
        w_illegal = 1'b0;
        case (r_inst[6:0])
            OPC_OP:
                w_illegal = !(r_inst[31:25] == 7'b0000000 ||
                              (r_inst[31:25] == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
            OPC_OPIMM:
                w_illegal = (w_f3 == 3'd1 && r_inst[31:25] != 7'b0000000) ||
                            (w_f3 == 3'd5 && r_inst[31:25] != 7'b0000000 && r_inst[31:25] != 7'b0100000);
            OPC_BRANCH:
                w_illegal = (w_f3 == 3'd2 || w_f3 == 3'd3);
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL:
                w_illegal = 1'b0;
            default:
                w_illegal = 1'b1;
        endcase
    end
`else
    assign w_illegal = 1'b0;
`endif

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.out_alu_sel = w_sel;
    assign bus.out_alu_ext = w_ext;
    assign bus.out_imm     = w_imm;
    assign bus.out_use_imm = w_useImm;
    assign bus.out_rs1     = r_inst[19:15];
    assign bus.out_rs2     = r_inst[24:20];
    assign bus.out_rd      = r_inst[11:7];
    assign bus.out_reg_we  = w_writes && (r_inst[11:7] != 5'd0) && !w_illegal;
    assign bus.out_illegal = w_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed RV32I cases plus randomized handshake/flush/reset traffic.
// Honours DECODE_ILLEGAL_CHECK_EN the same way the design does.
module tb_decode_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if bus();

    decode_stage #(.NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        ext;
        logic [31:0] imm;
        logic        useImm;
        logic        regWe;
        logic        illegal;
        logic        known;
    } expT;

    // Reference decode derived directly from the RV32I field rules.
    function automatic expT refDecode(input logic [31:0] i);
        expT e;
        logic [6:0]  opc  = i[6:0];
        logic [2:0]  f3   = i[14:12];
        logic [6:0]  f7   = i[31:25];
        logic [31:0] iImm = $unsigned($signed(i) >>> 20);
        logic        wr   = 1'b0;
        e = '{sel: 3'd0, ext: 1'b0, imm: 32'h0, useImm: 1'b0, regWe: 1'b0, illegal: 1'b0, known: 1'b1};
        if (opc == 7'h33) begin
            e.sel = f3; e.ext = i[30]; wr = 1'b1;
        end else if (opc == 7'h13) begin
            e.sel = f3; e.useImm = 1'b1; wr = 1'b1;
            e.ext = (f3 == 3'd5) ? i[30] : 1'b0;
            e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : iImm;
        end else if (opc == 7'h03 || opc == 7'h67) begin
            e.imm = iImm; e.useImm = 1'b1; wr = 1'b1;
        end else if (opc == 7'h23) begin
            e.imm = {iImm[31:5], i[11:7]}; e.useImm = 1'b1;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.imm = i & 32'hFFFFF000; e.useImm = 1'b1; wr = 1'b1;
        end else if (opc == 7'h6F) begin
            e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; e.useImm = 1'b1; wr = 1'b1;
        end else if (opc == 7'h63) begin
            e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            e.ext = (f3 <= 3'd1);
            e.sel = (f3 >= 3'd6) ? 3'd3 : (f3 >= 3'd4) ? 3'd2 : 3'd0;
        end else begin
            e.known = 1'b0;
        end
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (i[1:0] != 2'b11 || !e.known) e.illegal = 1'b1;
        if (opc == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) e.illegal = 1'b1;
        if (opc == 7'h13 && ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) e.illegal = 1'b1;
        if (opc == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) e.illegal = 1'b1;
`else
        if (f7 == 7'h7F && opc == 7'h7F) e.illegal = 1'b0;
`endif
        e.regWe = wr && (i[11:7] != 5'd0) && !e.illegal;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural occupancy model: one slot, updated with the same edge rules the execute side expects.
    logic        mValid = 1'b0;
    logic [31:0] mInst  = NOP;
    logic [31:0] mPc    = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid = 1'b0; mInst = NOP; mPc = 32'h0;
        end else if (bus.flush) begin
            mValid = 1'b0;
        end else if (bus.in_valid && (!mValid || bus.out_ready)) begin
            mValid = 1'b1; mInst = bus.in_inst; mPc = bus.in_pc;
        end else if (bus.out_ready) begin
            mValid = 1'b0;
        end
    end

    always @(negedge clk) begin
        expT e;
        e = refDecode(mInst);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(!mValid || bus.out_ready));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
        if (mValid) begin
            checkOutput("out_pc", bus.out_pc, mPc);
            checkOutput("out_alu_sel", 32'(bus.out_alu_sel), 32'(e.sel));
            checkOutput("out_alu_ext", 32'(bus.out_alu_ext), 32'(e.ext));
            checkOutput("out_rs1", 32'(bus.out_rs1), 32'(mInst[19:15]));
            checkOutput("out_rs2", 32'(bus.out_rs2), 32'(mInst[24:20]));
            checkOutput("out_rd", 32'(bus.out_rd), 32'(mInst[11:7]));
            checkOutput("out_reg_we", 32'(bus.out_reg_we), 32'(e.regWe));
            checkOutput("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
            if (e.known) begin
                checkOutput("out_imm", bus.out_imm, e.imm);
                checkOutput("out_use_imm", 32'(bus.out_use_imm), 32'(e.useImm));
            end
        end
    end

    function automatic logic [31:0] randInst();
        logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h0F, 7'h73};
        logic [6:0]  f7s  [3]  = '{7'h00, 7'h20, 7'h01};
        logic [31:0] i = $urandom;
        int          k = $urandom_range(0, 11);
        if (k < 11) i[6:0] = opcs[k];
        if ($urandom_range(0, 1) == 1) i[31:25] = f7s[$urandom_range(0, 2)];
        if ($urandom_range(0, 40) == 0) i = 32'h0;
        return i;
    endfunction

    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc;
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_inst = 32'h0; bus.in_pc = 32'h0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;

        rst = 1'b1; #1;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_pc", bus.out_pc, 32'h0);
        checkOutput("reset sel", 32'(bus.out_alu_sel), 32'd0);
        checkOutput("reset ext", 32'(bus.out_alu_ext), 32'd0);
        checkOutput("reset imm", bus.out_imm, 32'h0);
        checkOutput("reset use_imm", 32'(bus.out_use_imm), 32'd1);
        checkOutput("reset rd", 32'(bus.out_rd), 32'd0);
        checkOutput("reset reg_we", 32'(bus.out_reg_we), 32'd0);
        checkOutput("reset illegal", 32'(bus.out_illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(32'h402081B3, 32'h10);
        checkOutput("sub valid", 32'(bus.out_valid), 32'd1);
        checkOutput("sub sel", 32'(bus.out_alu_sel), 32'd0);
        checkOutput("sub ext", 32'(bus.out_alu_ext), 32'd1);
        checkOutput("sub rs1", 32'(bus.out_rs1), 32'd1);
        checkOutput("sub rs2", 32'(bus.out_rs2), 32'd2);
        checkOutput("sub rd", 32'(bus.out_rd), 32'd3);
        checkOutput("sub use_imm", 32'(bus.out_use_imm), 32'd0);
        checkOutput("sub reg_we", 32'(bus.out_reg_we), 32'd1);

        applyStimulus(32'h40335293, 32'h14);
        checkOutput("srai sel", 32'(bus.out_alu_sel), 32'd5);
        checkOutput("srai ext", 32'(bus.out_alu_ext), 32'd1);
        checkOutput("srai imm", bus.out_imm, 32'h00000003);
        checkOutput("srai use_imm", 32'(bus.out_use_imm), 32'd1);
        checkOutput("srai rd", 32'(bus.out_rd), 32'd5);

        applyStimulus(32'hFFF00093, 32'h18);
        checkOutput("addi sel", 32'(bus.out_alu_sel), 32'd0);
        checkOutput("addi ext", 32'(bus.out_alu_ext), 32'd0);
        checkOutput("addi imm", bus.out_imm, 32'hFFFFFFFF);
        checkOutput("addi reg_we", 32'(bus.out_reg_we), 32'd1);

        applyStimulus(32'h00000000, 32'h1C);
`ifdef DECODE_ILLEGAL_CHECK_EN
        checkOutput("zero illegal", 32'(bus.out_illegal), 32'd1);
`else
        checkOutput("zero illegal", 32'(bus.out_illegal), 32'd0);
`endif
        checkOutput("zero reg_we", 32'(bus.out_reg_we), 32'd0);

        // Back-pressure: hold A for three cycles while B waits upstream.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_inst = 32'h002081B3; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_inst = 32'h00C58633; bus.in_pc = 32'h104; bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall out_pc", bus.out_pc, 32'h100);
            checkOutput("stall out_rd", 32'(bus.out_rd), 32'd3);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("release valid", 32'(bus.out_valid), 32'd1);
        checkOutput("release out_pc", bus.out_pc, 32'h104);
        checkOutput("release out_rd", 32'(bus.out_rd), 32'd12);

        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_inst = 32'h00100093; bus.in_pc = 32'h200; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.in_inst = 32'h00200113; bus.in_pc = 32'h204; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush valid", 32'(bus.out_valid), 32'd0);

        applyStimulus(32'h00500293, 32'h300);
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst pc", bus.out_pc, 32'h0);
        checkOutput("midrst use_imm", 32'(bus.out_use_imm), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 199) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_inst   = randInst();
            bus.in_pc     = $urandom & 32'hFFFFFFFC;
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
